sonic_rx_page_dma_ctrl: RTL and testbench

Read-side sequencer for the 66-bit RX ring. It counts 66-bit blocks committed by blocksync and converts them into whole ready pages (496 blocks per 4 KB page). On a DMA page request it issues the 256 linear 128-bit ring read addresses for the oldest ready page, with backpressure, then retires that page. It sits between the DMA engine and the ring's rd_address port, in the same clock domain as both.

---
 rtl/sonic_constants.sv | 9 +
 rtl/sonic_rx_page_counter.sv | 36 +++
 rtl/sonic_rx_page_dma_ctrl.sv | 81 ++++++++
 tb/tb_sonic_rx_page_dma_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_constants.sv
// Shared sizing constants and FSM state encoding for the RX page DMA sequencer.
package sonic_constants;
    localparam int NUM_PAGES        = 32;
    localparam int BLKS_PER_PAGE    = 496;
    localparam int ENTRIES_PER_PAGE = 256;
    localparam int RD_LAT           = 2;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} dma_state_e;
endpackage

// File: rtl/sonic_rx_page_counter.sv
// Write-side block counter: turns committed 66-bit blocks into whole ready pages.
module sonic_rx_page_counter
    import sonic_constants::*;
(
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       wr_blk_valid,
    input  logic       dma_done,
    output logic [5:0] pages_ready,
    output logic       overflow
);
    logic [8:0] blk_cnt;
    logic       page_fill, full, ovf_nxt, fill_eff;

    assign page_fill = wr_blk_valid && (blk_cnt == 9'(BLKS_PER_PAGE - 1));
    assign full      = (pages_ready == 6'(NUM_PAGES));
    assign ovf_nxt   = overflow | (wr_blk_valid & full);
    // Once the writer has lapped the reader, completed pages no longer count.
    assign fill_eff  = page_fill & ~ovf_nxt;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            blk_cnt     <= '0;
            pages_ready <= '0;
            overflow    <= 1'b0;
        end else begin
            if (wr_blk_valid)
                blk_cnt <= page_fill ? 9'd0 : blk_cnt + 9'd1;
            overflow <= ovf_nxt;
            if (fill_eff && !dma_done)
                pages_ready <= pages_ready + 6'd1;
            else if (!fill_eff && dma_done && pages_ready != 6'd0)
                pages_ready <= pages_ready - 6'd1;
        end
    end
endmodule

// File: rtl/sonic_rx_page_dma_ctrl.sv
// Read-side sequencer: issues the 256 ring addresses of the oldest ready page per DMA request.
module sonic_rx_page_dma_ctrl
    import sonic_constants::*;
(
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        ctrl_enable,
    input  logic        wr_blk_valid,
    input  logic        dma_req,
    output logic        dma_req_ack,
    input  logic        dma_rd_ready,
    output logic [12:0] rd_address,
    output logic        rd_valid,
    output logic        rd_data_valid,
    output logic        rd_last,
    output logic        dma_done,
    output logic [5:0]  pages_ready,
    output logic        overflow
);
    dma_state_e        state, state_nxt;
    logic [4:0]        rd_page;
    logic [7:0]        offset;
    logic              ack_nxt, rd_fire, last_fire;
    logic [RD_LAT-1:0] vld_pipe, last_pipe;

    sonic_rx_page_counter u_cnt (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .wr_blk_valid (wr_blk_valid),
        .dma_done     (dma_done),
        .pages_ready  (pages_ready),
        .overflow     (overflow)
    );

    assign rd_valid      = (state == BURST);
    assign rd_address    = {rd_page, offset};
    assign rd_fire       = rd_valid & dma_rd_ready;
    assign last_fire     = rd_fire && (offset == 8'(ENTRIES_PER_PAGE - 1));
    assign rd_data_valid = vld_pipe[RD_LAT-1];
    assign rd_last       = last_pipe[RD_LAT-1];

    // dma_done lands one cycle before pages_ready drops, so it also blocks a stale accept.
    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        case (state)
            IDLE:  if (ctrl_enable && dma_req && pages_ready != 6'd0 && !dma_done) begin
                       state_nxt = BURST;
                       ack_nxt   = 1'b1;
                   end
            BURST: if (last_fire) state_nxt = DRAIN;
            DRAIN: if (rd_last) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rd_page     <= '0;
            offset      <= '0;
            dma_req_ack <= 1'b0;
            dma_done    <= 1'b0;
            vld_pipe    <= '0;
            last_pipe   <= '0;
        end else begin
            state       <= state_nxt;
            dma_req_ack <= ack_nxt;
            dma_done    <= (state == DONE);
            if (ack_nxt)
                offset <= '0;
            else if (rd_fire)
                offset <= offset + 8'd1;
            if (state == DONE)
                rd_page <= rd_page + 5'd1;
            vld_pipe  <= {vld_pipe[RD_LAT-2:0], rd_fire};
            last_pipe <= {last_pipe[RD_LAT-2:0], last_fire};
        end
    end
endmodule

// File: tb/tb_sonic_rx_page_dma_ctrl.sv
// Scoreboard bench: stimulus queues expected read addresses/last flags, a negedge monitor checks them.
module tb_sonic_rx_page_dma_ctrl;
    localparam int LAT = 2;

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_enable = 1'b1;
    logic        wr_blk_valid = 1'b0;
    logic        dma_req = 1'b0;
    logic        dma_rd_ready = 1'b1;
    logic        dma_req_ack, rd_valid, rd_data_valid, rd_last, dma_done, overflow;
    logic [12:0] rd_address;
    logic [5:0]  pages_ready;

    int          checks = 0;
    int          failures = 0;
    logic [12:0] addr_q[$];
    bit          last_q[$];
    int          exp_page = 0;
    int          exp_pages = 0;

    sonic_rx_page_dma_ctrl dut (
        .clk_in        (clk_in),
        .reset_n       (reset_n),
        .ctrl_enable   (ctrl_enable),
        .wr_blk_valid  (wr_blk_valid),
        .dma_req       (dma_req),
        .dma_req_ack   (dma_req_ack),
        .dma_rd_ready  (dma_rd_ready),
        .rd_address    (rd_address),
        .rd_valid      (rd_valid),
        .rd_data_valid (rd_data_valid),
        .rd_last       (rd_last),
        .dma_done      (dma_done),
        .pages_ready   (pages_ready),
        .overflow      (overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Monitor: every accepted read and every returned data beat consumes one queued expectation.
    always @(negedge clk_in) begin
        if (reset_n) begin
            if (rd_valid && dma_rd_ready) begin
                if (addr_q.size() == 0) chk("rd_address_unexpected", {19'd0, rd_address}, 32'hFFFF_FFFF);
                else chk("rd_address", {19'd0, rd_address}, {19'd0, addr_q.pop_front()});
            end
            if (rd_data_valid) begin
                if (last_q.size() == 0) chk("rd_data_valid_unexpected", 32'd1, 32'd0);
                else chk("rd_last", {31'd0, rd_last}, {31'd0, last_q.pop_front()});
            end
        end
    end

    task automatic fill_blocks(input int n);
        wr_blk_valid = 1'b1;
        repeat (n) tick();
        wr_blk_valid = 1'b0;
    endtask

    task automatic push_page();
        logic [4:0] pg;
        pg = 5'(exp_page);
        for (int off = 0; off < 256; off++) begin
            addr_q.push_back({pg, 8'(off)});
            last_q.push_back(off == 255);
        end
    endtask

    // Raise dma_req and expect the ack exactly one cycle later.
    task automatic request_page(output bit ok);
        int n;
        dma_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!dma_req_ack && n < 50);
        ok = dma_req_ack;
        chk("ack_latency", n, 1);
    endtask

    // Called in the cycle the ack is visible; runs the page to dma_done and checks retirement.
    task automatic finish_burst(input bit toggle, input bit fill_on_done, input int exp_lat);
        int n;
        dma_req = 1'b0;
        push_page();
        if (toggle) dma_rd_ready = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) chk("ack_pulse", {31'd0, dma_req_ack}, 0);
            if (toggle) dma_rd_ready = ~dma_rd_ready;
        end while (!dma_done && n < 2000);
        dma_rd_ready = 1'b1;
        chk("done_latency", n + 1, exp_lat);
        if (fill_on_done) wr_blk_valid = 1'b1;
        tick();
        wr_blk_valid = 1'b0;
        if (!fill_on_done) exp_pages--;
        exp_page = (exp_page + 1) % 32;
        chk("done_pulse", {31'd0, dma_done}, 0);
        chk("pages_after_done", {26'd0, pages_ready}, exp_pages);
    endtask

    task automatic full_page_cycle(input bit toggle);
        bit ok;
        request_page(ok);
        if (ok) finish_burst(toggle, 1'b0, toggle ? 512 + LAT + 2 : 256 + LAT + 2);
        else dma_req = 1'b0;
    endtask

    initial begin
        bit ok;
        int acks;
        // Reset state
        #2;
        chk("rst_rd_valid", {31'd0, rd_valid}, 0);
        chk("rst_pages", {26'd0, pages_ready}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_address", {19'd0, rd_address}, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // One page: 495 blocks leave it incomplete, the 496th completes it
        fill_blocks(495);
        chk("pages_495", {26'd0, pages_ready}, 0);
        fill_blocks(1);
        exp_pages = 1;
        chk("pages_496", {26'd0, pages_ready}, 1);
        full_page_cycle(1'b0);

        // Request with nothing ready stays pending; ack follows the page becoming ready
        dma_req = 1'b1;
        acks = 0;
        repeat (100) begin
            tick();
            if (dma_req_ack) acks++;
        end
        chk("no_ack_when_empty", acks, 0);
        fill_blocks(496);
        exp_pages = 1;
        chk("pages_pending", {26'd0, pages_ready}, 1);
        chk("ack_not_yet", {31'd0, dma_req_ack}, 0);
        tick();
        chk("ack_after_ready", {31'd0, dma_req_ack}, 1);
        if (dma_req_ack) finish_burst(1'b0, 1'b0, 256 + LAT + 2);
        else dma_req = 1'b0;

        // Backpressure 1,0,1,0 with ctrl_enable dropped mid-burst
        fill_blocks(496);
        exp_pages = 1;
        request_page(ok);
        ctrl_enable = 1'b0;
        if (ok) finish_burst(1'b1, 1'b0, 512 + LAT + 2);
        else dma_req = 1'b0;
        ctrl_enable = 1'b1;

        // Pages 3..31 then the wrap back to page 0
        fill_blocks(29 * 496);
        exp_pages = 29;
        chk("pages_29", {26'd0, pages_ready}, 29);
        repeat (29) full_page_cycle(1'b0);
        chk("page_wrapped", exp_page, 0);
        fill_blocks(496);
        exp_pages = 1;
        full_page_cycle(1'b0);

        // Overflow: 32 full pages then one more block
        fill_blocks(32 * 496);
        exp_pages = 32;
        chk("pages_full", {26'd0, pages_ready}, 32);
        chk("no_overflow_yet", {31'd0, overflow}, 0);
        fill_blocks(1);
        chk("overflow_set", {31'd0, overflow}, 1);
        chk("pages_saturated", {26'd0, pages_ready}, 32);

        // Reset clears the sticky overflow; then page_fill coincides with dma_done
        reset_n = 1'b0;
        #1;
        chk("rst2_overflow", {31'd0, overflow}, 0);
        chk("rst2_pages", {26'd0, pages_ready}, 0);
        tick();
        reset_n = 1'b1;
        exp_page = 0;
        exp_pages = 0;
        tick();
        fill_blocks(496 + 495);
        exp_pages = 1;
        request_page(ok);
        if (ok) finish_burst(1'b0, 1'b1, 256 + LAT + 2);
        else dma_req = 1'b0;
        chk("fill_and_done", {26'd0, pages_ready}, 1);

        // Reset at offset 100 of the page-1 burst
        request_page(ok);
        dma_req = 1'b0;
        if (ok) begin
            push_page();
            repeat (100) tick();
            chk("mid_burst_addr", {19'd0, rd_address}, 32'h0164);
        end
        reset_n = 1'b0;
        #1;
        chk("rst3_rd_valid", {31'd0, rd_valid}, 0);
        chk("rst3_rd_data_valid", {31'd0, rd_data_valid}, 0);
        chk("rst3_pages", {26'd0, pages_ready}, 0);
        chk("rst3_overflow", {31'd0, overflow}, 0);
        addr_q.delete();
        last_q.delete();
        tick();
        reset_n = 1'b1;
        exp_page = 0;
        exp_pages = 0;
        tick();
        fill_blocks(496);
        exp_pages = 1;
        full_page_cycle(1'b0);

        repeat (5) tick();
        chk("addr_q_drained", addr_q.size(), 0);
        chk("last_q_drained", last_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
